// File: rtl/window_fetch_sequencer_if.sv
// Avalon-MM master bus used by the window fetch sequencer to reach source and
// destination image memory.
interface window_fetch_sequencer_if;
    logic        master_read;
    logic        master_write;
    logic [31:0] master_address;
    logic [31:0] master_writedata;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_writeresponsevalid;

    modport master (
        output master_read,
        output master_write,
        output master_address,
        output master_writedata,
        input  master_readdata,
        input  master_readdatavalid,
        input  master_writeresponsevalid
    );

    modport slave (
        input  master_read,
        input  master_write,
        input  master_address,
        input  master_writedata,
        output master_readdata,
        output master_readdatavalid,
        output master_writeresponsevalid
    );
endinterface

// File: rtl/window_fetch_sequencer.sv
// Raster-scans interior pixels, fetches each 3x3 neighbourhood over Avalon, feeds the
// cartoonify pipeline and writes the filtered pixel back. One transaction in flight.
module window_fetch_sequencer #(
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter logic [31:0] SRC_BASE = 32'h0000_0000,
    parameter logic [31:0] DST_BASE = 32'h0010_0000
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    window_fetch_sequencer_if.master bus,
    output logic [215:0]             pixel_data,
    output logic                     pixel_enable,
    input  logic                     pixel_done,
    input  logic [23:0]              f_pixel,
    output logic                     busy,
    output logic                     frame_done
);
    localparam logic [31:0] ImgW       = 32'(IMG_W);
    localparam logic [31:0] XLast      = 32'(IMG_W - 2);
    localparam logic [31:0] YLast      = 32'(IMG_H - 2);
    localparam bit          Degenerate = (IMG_W < 3) || (IMG_H < 3);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StProc,
        StWrReq,
        StWrWait,
        StNext,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       x_q, x_d;
    logic [31:0]       y_q, y_d;
    logic [3:0]        tap_q, tap_d;
    logic [8:0][23:0]  win_q, win_d;
    logic [31:0]       wdata_q, wdata_d;
    // Set once pixel_enable has fired in the current PROC visit.
    logic              fired_q, fired_d;

    logic [31:0]       tap_dx, tap_dy, rd_row, rd_col, rd_addr, wr_addr;
    logic              unused_rdata_hi;

    assign unused_rdata_hi = ^bus.master_readdata[31:24];

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= StIdle;
            x_q     <= 32'd1;
            y_q     <= 32'd1;
            tap_q   <= 4'd0;
            win_q   <= '0;
            wdata_q <= 32'd0;
            fired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tap_q   <= tap_d;
            win_q   <= win_d;
            wdata_q <= wdata_d;
            fired_q <= fired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        tap_d        = tap_q;
        win_d        = win_q;
        wdata_d      = wdata_q;
        fired_d      = 1'b0;
        pixel_enable = 1'b0;
        frame_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = 32'd1;
                    y_d     = 32'd1;
                    tap_d   = 4'd0;
                    state_d = Degenerate ? StDone : StRdReq;
                end
            end
            StRdReq: state_d = StRdWait;
            StRdWait: begin
                if (bus.master_readdatavalid) begin
                    win_d[tap_q] = bus.master_readdata[23:0];
                    if (tap_q == 4'd8) begin
                        tap_d   = 4'd0;
                        state_d = StProc;
                    end else begin
                        tap_d   = tap_q + 4'd1;
                        state_d = StRdReq;
                    end
                end
            end
            StProc: begin
                fired_d      = 1'b1;
                pixel_enable = !fired_q;
                // A done coincident with the enable pulse cannot be a real result.
                if (fired_q && pixel_done) begin
                    wdata_d = {8'h00, f_pixel};
                    state_d = StWrReq;
                end
            end
            StWrReq: state_d = StWrWait;
            StWrWait: begin
                if (bus.master_writeresponsevalid) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (x_q == XLast) begin
                    x_d = 32'd1;
                    y_d = y_q + 32'd1;
                end else begin
                    x_d = x_q + 32'd1;
                end
                state_d = (x_q == XLast && y_q == YLast) ? StDone : StRdReq;
            end
            StDone: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tap_dy  = 32'(tap_q / 4'd3);
        tap_dx  = 32'(tap_q % 4'd3);
        rd_row  = y_q + tap_dy - 32'd1;
        rd_col  = x_q + tap_dx - 32'd1;
        rd_addr = SRC_BASE + (rd_row * ImgW + rd_col) * 32'd4;
        wr_addr = DST_BASE + (y_q * ImgW + x_q) * 32'd4;
    end

    assign bus.master_read      = (state_q == StRdReq);
    assign bus.master_write     = (state_q == StWrReq);
    assign bus.master_address   = (state_q == StRdReq) ? rd_addr :
                                  (state_q == StWrReq) ? wr_addr : 32'd0;
    assign bus.master_writedata = wdata_q;
    assign pixel_data           = win_q;
    assign busy                 = (state_q != StIdle) && (state_q != StDone);
endmodule

// File: tb/tb_window_fetch_sequencer.sv
// Bench for window_fetch_sequencer: 4x4 frames against a scoreboard of expected reads,
// windows and writes under random latencies and spurious pulses, plus a 2-wide instance.
module tb_window_fetch_sequencer;
    localparam int unsigned W   = 4;
    localparam int unsigned H   = 4;
    localparam logic [31:0] SRC = 32'h0000_0000;
    localparam logic [31:0] DST = 32'h0000_0100;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         start = 1'b0;
    logic         start2 = 1'b0;
    logic [215:0] pixel_data, pixel_data2;
    logic         pixel_enable, pixel_enable2;
    logic         pixel_done = 1'b0;
    logic [23:0]  f_pixel = 24'd0;
    logic         busy, busy2, frame_done, frame_done2;

    window_fetch_sequencer_if bus ();
    window_fetch_sequencer_if bus2 ();

    window_fetch_sequencer #(.IMG_W(W), .IMG_H(H), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .bus          (bus),
        .pixel_data   (pixel_data),
        .pixel_enable (pixel_enable),
        .pixel_done   (pixel_done),
        .f_pixel      (f_pixel),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    window_fetch_sequencer #(.IMG_W(2), .IMG_H(4), .SRC_BASE(SRC), .DST_BASE(DST)) dut2 (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start2),
        .bus          (bus2),
        .pixel_data   (pixel_data2),
        .pixel_enable (pixel_enable2),
        .pixel_done   (1'b0),
        .f_pixel      (24'd0),
        .busy         (busy2),
        .frame_done   (frame_done2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]  exp_rd[$];
    logic [31:0]  exp_wa[$];
    logic [31:0]  exp_wd[$];
    logic [215:0] exp_win[$];

    int           rd_idx, wr_idx, win_idx, n_fd, proto_err;
    bit           rd_pend, wr_pend, px_pend;
    int           rd_cnt, wr_cnt, px_cnt;
    logic [31:0]  rd_val;
    logic [23:0]  px_val;
    logic [215:0] held_win;

    task automatic check(input string tag, input logic [215:0] got, input logic [215:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected transactions straight from the scan/window/address rules.
    task automatic build_model();
        int          cx, cy;
        logic [31:0] a;
        logic [215:0] win;
        for (int py = 1; py <= int'(H) - 2; py++) begin
            for (int px = 1; px <= int'(W) - 2; px++) begin
                win = '0;
                for (int k = 0; k < 9; k++) begin
                    cx = px + (k % 3) - 1;
                    cy = py + (k / 3) - 1;
                    a  = SRC + 32'((cy * int'(W) + cx) * 4);
                    exp_rd.push_back(a);
                    win[24 * k +: 24] = a[23:0];
                end
                exp_win.push_back(win);
                exp_wa.push_back(DST + 32'((py * int'(W) + px) * 4));
                a = SRC + 32'((py * int'(W) + px) * 4);
                exp_wd.push_back({8'h00, a[23:0]});
            end
        end
    endtask

    task automatic run_frame(input int max_dly, input bit spur, input bit poke,
                             output int cycles);
        bit seen_fd   = 1'b0;
        bit prev_busy = 1'b0;
        rd_idx = 0; wr_idx = 0; win_idx = 0; n_fd = 0; proto_err = 0;
        rd_pend = 1'b0; wr_pend = 1'b0; px_pend = 1'b0;
        cycles = 0;
        start = 1'b1;
        while (!seen_fd && cycles < 5000) begin
            tick();
            cycles++;
            start = 1'b0;
            bus.master_readdatavalid      = 1'b0;
            bus.master_writeresponsevalid = 1'b0;
            pixel_done                    = 1'b0;

            if (bus.master_read && bus.master_write) proto_err++;
            if ((bus.master_read || bus.master_write) && (rd_pend || wr_pend || px_pend))
                proto_err++;
            if (!bus.master_read && !bus.master_write && bus.master_address != 32'd0)
                proto_err++;
            if (px_pend && (pixel_data != held_win || pixel_enable)) proto_err++;
            if (frame_done) begin
                seen_fd = 1'b1;
                n_fd++;
                check("busy_low_at_done", 216'(busy), 216'(0));
                check("busy_before_done", 216'(prev_busy), 216'(1));
            end
            prev_busy = busy;

            // Responses due this cycle, or junk pulses when nothing is owed.
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    bus.master_readdatavalid = 1'b1;
                    bus.master_readdata      = rd_val;
                    rd_pend = 1'b0;
                end else rd_cnt--;
            end else if (spur && $urandom_range(0, 2) == 0) begin
                bus.master_readdatavalid = 1'b1;
                bus.master_readdata      = $urandom;
            end
            if (wr_pend) begin
                if (wr_cnt == 0) begin
                    bus.master_writeresponsevalid = 1'b1;
                    wr_pend = 1'b0;
                end else wr_cnt--;
            end else if (spur && $urandom_range(0, 2) == 0) begin
                bus.master_writeresponsevalid = 1'b1;
            end
            if (px_pend) begin
                if (px_cnt == 0) begin
                    pixel_done = 1'b1;
                    f_pixel    = px_val;
                    px_pend    = 1'b0;
                end else px_cnt--;
            end else if (spur && $urandom_range(0, 2) == 0) begin
                pixel_done = 1'b1;
                f_pixel    = 24'($urandom);
            end

            // New requests seen this cycle; earliest answer is next cycle.
            if (bus.master_read) begin
                if (rd_idx < exp_rd.size())
                    check($sformatf("rd_addr[%0d]", rd_idx), 216'(bus.master_address),
                          216'(exp_rd[rd_idx]));
                else check("rd_extra", 216'(rd_idx), 216'(exp_rd.size()));
                rd_idx++;
                rd_pend = 1'b1;
                rd_cnt  = $urandom_range(0, max_dly);
                rd_val  = {8'($urandom), bus.master_address[23:0]};
                if (poke) start = 1'b1;
            end
            if (bus.master_write) begin
                if (wr_idx < exp_wa.size()) begin
                    check($sformatf("wr_addr[%0d]", wr_idx), 216'(bus.master_address),
                          216'(exp_wa[wr_idx]));
                    check($sformatf("wr_data[%0d]", wr_idx), 216'(bus.master_writedata),
                          216'(exp_wd[wr_idx]));
                end else check("wr_extra", 216'(wr_idx), 216'(exp_wa.size()));
                wr_idx++;
                wr_pend = 1'b1;
                wr_cnt  = $urandom_range(0, max_dly);
            end
            if (pixel_enable) begin
                if (win_idx < exp_win.size())
                    check($sformatf("window[%0d]", win_idx), pixel_data, exp_win[win_idx]);
                else check("enable_extra", 216'(win_idx), 216'(exp_win.size()));
                win_idx++;
                held_win = pixel_data;
                px_pend  = 1'b1;
                px_cnt   = $urandom_range(0, max_dly);
                px_val   = pixel_data[119:96];
                if (poke) start = 1'b1;
            end
            if (poke && busy && $urandom_range(0, 3) == 0) start = 1'b1;
        end
        start = 1'b0;
        bus.master_readdatavalid      = 1'b0;
        bus.master_writeresponsevalid = 1'b0;
        pixel_done                    = 1'b0;
        check("frame_done_seen", 216'(seen_fd), 216'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.master_read || bus.master_write || frame_done || busy || pixel_enable)
                proto_err++;
        end
        check("read_count", 216'(rd_idx), 216'(exp_rd.size()));
        check("write_count", 216'(wr_idx), 216'(exp_wa.size()));
        check("enable_count", 216'(win_idx), 216'(exp_win.size()));
        check("frame_done_count", 216'(n_fd), 216'(1));
        check("protocol_errors", 216'(proto_err), 216'(0));
        check("writedata_held", 216'(bus.master_writedata), 216'(exp_wd[exp_wd.size() - 1]));
    endtask

    initial begin
        int cycles;
        bus.master_readdata            = 32'd0;
        bus.master_readdatavalid       = 1'b0;
        bus.master_writeresponsevalid  = 1'b0;
        bus2.master_readdata           = 32'd0;
        bus2.master_readdatavalid      = 1'b0;
        bus2.master_writeresponsevalid = 1'b0;
        build_model();

        repeat (3) tick();
        n_rst = 1'b0;
        tick();
        check("reset_outputs",
              {pixel_data[215:144], busy, frame_done, pixel_enable, bus.master_read,
               bus.master_write, bus.master_address, bus.master_writedata},
              216'(0));
        check("reset_window", pixel_data, 216'(0));

        // Zero-wait memory and pipeline: 23 cycles per pixel, then the DONE cycle.
        run_frame(0, 1'b0, 1'b0, cycles);
        check("min_latency", 216'(cycles), 216'(4 * 23 + 1));

        run_frame(5, 1'b1, 1'b0, cycles);
        run_frame(5, 1'b1, 1'b1, cycles);

        // Reset while a read is outstanding, then answer the dead read.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_first_read", 216'(bus.master_read), 216'(1));
        tick();
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0;
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata      = 32'h00AB_CDEF;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_quiet[%0d]", i),
                  {busy, frame_done, pixel_enable, bus.master_read, bus.master_write,
                   bus.master_address, bus.master_writedata},
                  216'(0));
            check($sformatf("rst_window[%0d]", i), pixel_data, 216'(0));
            tick();
            bus.master_readdatavalid = 1'b0;
        end
        run_frame(3, 1'b1, 1'b0, cycles);

        // Degenerate width: DONE immediately, no bus activity.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("w2_done_pulse", 216'(frame_done2), 216'(1));
        check("w2_busy", 216'(busy2), 216'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("w2_quiet[%0d]", i),
                  {frame_done2, busy2, pixel_enable2, bus2.master_read, bus2.master_write},
                  216'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
